// File: rtl/boruhatti_toplama_agaci_if.sv
// Handshake and data bundle of the pipelined adder tree.
// The source drives operands and the input valid, the consumer drives cikis_hazir;
// the tree answers with giris_hazir and the registered sum.
interface boruhatti_toplama_agaci_if #(
   parameter int N = 8,
   parameter int K = 8
);
   localparam int L = $clog2(K);

   logic [K*N-1:0] sayilar;
   logic           giris_etkin;
   logic           giris_hazir;
   logic [N+L-1:0] sonuc;
   logic           sonuc_etkin;
   logic           cikis_hazir;

   // Environment side: produces operands, consumes results.
   modport master (
      output sayilar, giris_etkin, cikis_hazir,
      input  giris_hazir, sonuc, sonuc_etkin
   );

   // Adder tree side.
   modport slave (
      input  sayilar, giris_etkin, cikis_hazir,
      output giris_hazir, sonuc, sonuc_etkin
   );
endinterface

// File: rtl/boruhatti_toplama_agaci.sv
// Pipelined adder tree: K operands of N bits summed over log2(K) register stages.
// Every stage widens by one bit, so the final sum is exact in N+L bits.
// A single global advance signal stalls the whole pipe while the consumer refuses
// a valid result; bubbles are kept in place during a stall.
module boruhatti_toplama_agaci #(
   parameter int N        = 8,
   parameter int K        = 8,
   parameter int ISARETLI = 0
) (
   input logic                       clk,
   input logic                       rst,
   boruhatti_toplama_agaci_if.slave  bus
);
   localparam int L = $clog2(K);

   logic         ilerle;
   logic [L-1:0] v;

   assign ilerle          = !v[L-1] || bus.cikis_hazir;
   assign bus.giris_hazir = ilerle && !rst;
   assign bus.sonuc_etkin = v[L-1];

   // Valid bits shift one stage per advancing edge; v[0] belongs to stage 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         v <= '0;
      end else if (ilerle) begin
         v <= (v << 1) | L'(bus.giris_etkin);
      end
   end

   for (genvar s = 1; s <= L; s++) begin : g_kademe
      localparam int W = N + s;
      localparam int C = K >> s;

      logic [2*C*(W-1)-1:0] alt;
      logic [C*W-1:0]       sonraki;
      logic [C*W-1:0]       toplam;
      logic [W-2:0]         sol;
      logic [W-2:0]         sag;

      if (s == 1) begin : g_kaynak
         assign alt = bus.sayilar;
      end else begin : g_kaynak
         assign alt = g_kademe[s-1].toplam;
      end

      // Pairwise sums of the stage below, each addend sign- or zero-extended by one bit.
      always_comb begin
         sonraki = '0;
         sol     = '0;
         sag     = '0;
         for (int j = 0; j < C; j++) begin
            sol = alt[2*j*(W-1) +: W-1];
            sag = alt[(2*j+1)*(W-1) +: W-1];
            sonraki[j*W +: W] = {(ISARETLI != 0) && sol[W-2], sol}
                              + {(ISARETLI != 0) && sag[W-2], sag};
         end
      end

      // Partial sums load whenever the pipe advances, regardless of the valid bit.
      always_ff @(posedge clk) begin
         if (rst) begin
            toplam <= '0;
         end else if (ilerle) begin
            toplam <= sonraki;
         end
      end
   end

   assign bus.sonuc = g_kademe[L].toplam;
endmodule

// File: tb/tb_boruhatti_toplama_agaci.sv
// Self-checking bench for the pipelined adder tree: an 8x8 unsigned and an 8x8 signed
// instance share one stimulus stream and are scored against queues of arithmetic sums;
// a 2x4 unsigned and a 16x16 signed instance cover the parameter extremes.
module tb_boruhatti_toplama_agaci;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic [63:0]  sayilar8;
   logic         etkin8;
   logic         hazir8;
   logic [7:0]   sayilar2;
   logic         etkin2;
   logic [255:0] sayilar16;
   logic         etkin16;

   boruhatti_toplama_agaci_if #(.N(8),  .K(8))  bus8u ();
   boruhatti_toplama_agaci_if #(.N(8),  .K(8))  bus8s ();
   boruhatti_toplama_agaci_if #(.N(4),  .K(2))  bus2 ();
   boruhatti_toplama_agaci_if #(.N(16), .K(16)) bus16 ();

   assign bus8u.sayilar     = sayilar8;
   assign bus8u.giris_etkin = etkin8;
   assign bus8u.cikis_hazir = hazir8;
   assign bus8s.sayilar     = sayilar8;
   assign bus8s.giris_etkin = etkin8;
   assign bus8s.cikis_hazir = hazir8;
   assign bus2.sayilar      = sayilar2;
   assign bus2.giris_etkin  = etkin2;
   assign bus2.cikis_hazir  = 1'b1;
   assign bus16.sayilar     = sayilar16;
   assign bus16.giris_etkin = etkin16;
   assign bus16.cikis_hazir = 1'b1;

   boruhatti_toplama_agaci #(.N(8),  .K(8),  .ISARETLI(0)) dut8u  (.clk(clk), .rst(rst), .bus(bus8u));
   boruhatti_toplama_agaci #(.N(8),  .K(8),  .ISARETLI(1)) dut8s  (.clk(clk), .rst(rst), .bus(bus8s));
   boruhatti_toplama_agaci #(.N(4),  .K(2),  .ISARETLI(0)) dut2   (.clk(clk), .rst(rst), .bus(bus2));
   boruhatti_toplama_agaci #(.N(16), .K(16), .ISARETLI(1)) dut16  (.clk(clk), .rst(rst), .bus(bus16));

   int check_count = 0;
   int error_count = 0;
   int out_count   = 0;
   logic prev_stall = 1'b0;
   logic [10:0] q_u[$];
   logic [10:0] q_s[$];

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Plain arithmetic sums of the eight operands, as unsigned and as two's complement.
   function automatic logic [10:0] model_u(input logic [63:0] ops);
      int t = 0;
      for (int i = 0; i < 8; i++) t += int'(ops[i*8 +: 8]);
      return t[10:0];
   endfunction

   function automatic logic [10:0] model_s(input logic [63:0] ops);
      int t = 0;
      for (int i = 0; i < 8; i++) t += int'($signed(ops[i*8 +: 8]));
      return t[10:0];
   endfunction

   // Evaluated at the falling edge with this cycle's inputs settled.
   task automatic updateScoreboard();
      checkOutput("hazir_kurali", bus8u.giris_hazir, !bus8u.sonuc_etkin || hazir8);
      if (prev_stall) checkOutput("durma_etkin", bus8u.sonuc_etkin, 1'b1);
      if (bus8u.sonuc_etkin) begin
         if (q_u.size() == 0) begin
            checkOutput("fazla_sonuc", 1'b1, 1'b0);
         end else begin
            checkOutput("toplam_u", bus8u.sonuc, q_u[0]);
            checkOutput("toplam_s", bus8s.sonuc, q_s[0]);
            checkOutput("etkin_s", bus8s.sonuc_etkin, 1'b1);
            if (hazir8) begin
               void'(q_u.pop_front());
               void'(q_s.pop_front());
               out_count++;
            end
         end
      end
      if (etkin8 && bus8u.giris_hazir) begin
         q_u.push_back(model_u(sayilar8));
         q_s.push_back(model_s(sayilar8));
      end
      prev_stall = bus8u.sonuc_etkin && !hazir8;
   endtask

   task automatic tick();
      @(negedge clk);
      updateScoreboard();
      @(posedge clk);
      #1;
   endtask

   // Presents the current operands for one cycle and checks exact latency on every instance.
   task automatic applyStimulus(input logic v2, input logic [63:0] exp2, input logic v16, input logic [63:0] exp16);
      hazir8 = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         checkOutput("gecikme_8u", bus8u.sonuc_etkin, k == 3);
         checkOutput("gecikme_8s", bus8s.sonuc_etkin, k == 3);
         checkOutput("gecikme_2", bus2.sonuc_etkin, v2 && (k == 1));
         if (v2 && (k == 1)) checkOutput("toplam_2", bus2.sonuc, exp2);
         checkOutput("gecikme_16", bus16.sonuc_etkin, v16 && (k == 4));
         if (v16 && (k == 4)) checkOutput("toplam_16", bus16.sonuc, exp16);
         updateScoreboard();
         @(posedge clk);
         #1;
         etkin8  = 1'b0;
         etkin2  = 1'b0;
         etkin16 = 1'b0;
      end
   endtask

   task automatic applyReset();
      rst     = 1'b1;
      etkin8  = 1'b0;
      etkin2  = 1'b0;
      etkin16 = 1'b0;
      @(negedge clk);
      checkOutput("rst_hazir", bus8u.giris_hazir, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q_u.delete();
      q_s.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      checkOutput("rst_etkin_u", bus8u.sonuc_etkin, 1'b0);
      checkOutput("rst_toplam_u", bus8u.sonuc, 11'd0);
      checkOutput("rst_etkin_s", bus8s.sonuc_etkin, 1'b0);
      checkOutput("rst_toplam_s", bus8s.sonuc, 11'd0);
      checkOutput("rst_toplam_16", bus16.sonuc, 20'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      etkin8 = 1'b0;
      hazir8 = 1'b1;
      for (int i = 0; i < 20 && q_u.size() > 0; i++) tick();
      checkOutput(tag, q_u.size(), 0);
   endtask

   initial begin
      rst       = 1'b1;
      hazir8    = 1'b1;
      etkin8    = 1'b0;
      etkin2    = 1'b0;
      etkin16   = 1'b0;
      sayilar8  = '0;
      sayilar2  = '0;
      sayilar16 = '0;
      repeat (2) @(posedge clk);
      #1;
      applyReset();

      // All-ones unsigned, plus the two parameter extremes in the same cycle.
      sayilar8  = {8{8'hFF}};
      sayilar2  = 8'hFF;
      sayilar16 = {16{16'h7FFF}};
      etkin8 = 1'b1; etkin2 = 1'b1; etkin16 = 1'b1;
      applyStimulus(1'b1, 64'd30, 1'b1, 64'h7FFF0);

      // Most negative operands and alternating +1/-1.
      sayilar8 = {8{8'h80}};
      etkin8 = 1'b1;
      applyStimulus(1'b0, 64'd0, 1'b0, 64'd0);
      sayilar8 = {4{8'hFF, 8'h01}};
      etkin8 = 1'b1;
      applyStimulus(1'b0, 64'd0, 1'b0, 64'd0);

      // Back-to-back stream: twenty results must come out in twenty consecutive cycles.
      out_count = 0;
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < 8; i++) sayilar8[i*8 +: 8] = 8'(c + i);
         etkin8 = 1'b1;
         tick();
      end
      etkin8 = 1'b0;
      repeat (3) tick();
      checkOutput("akis_sayisi", out_count, 20);
      drain("akis_bosalma");

      // Same stream with the consumer stalling for four cycles.
      begin
         int c = 0;
         int cyc = 0;
         logic kabul;
         while (c < 20 && cyc < 100) begin
            for (int i = 0; i < 8; i++) sayilar8[i*8 +: 8] = 8'(c + i);
            etkin8 = 1'b1;
            hazir8 = !(cyc >= 8 && cyc < 12);
            @(negedge clk);
            kabul = etkin8 && bus8u.giris_hazir;
            if (!hazir8) checkOutput("durma_hazir", bus8u.giris_hazir, 1'b0);
            updateScoreboard();
            @(posedge clk);
            #1;
            if (kabul) c++;
            cyc++;
         end
         checkOutput("durma_akis_bitti", c, 20);
      end
      drain("durma_bosalma");

      // Two sums in flight, then a reset: nothing stale may appear afterwards.
      for (int i = 0; i < 2; i++) begin
         sayilar8 = {$urandom, $urandom};
         etkin8 = 1'b1;
         tick();
      end
      applyReset();
      repeat (6) tick();
      sayilar8  = {$urandom, $urandom};
      sayilar2  = {4'h3, 4'hA};
      sayilar16 = {16{16'h8000}};
      etkin8 = 1'b1; etkin2 = 1'b1; etkin16 = 1'b1;
      applyStimulus(1'b1, 64'd13, 1'b1, 64'h80000);

      // Random operands, random input valid and random consumer stalls.
      for (int n = 0; n < 400; n++) begin
         sayilar8 = {$urandom, $urandom};
         etkin8   = ($urandom_range(0, 9) < 7);
         hazir8   = ($urandom_range(0, 9) < 7);
         tick();
      end
      drain("rastgele_bosalma");

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end
endmodule
